// File: rtl/rp_spi_slave.sv
// SPI mode-0 target: oversamples cs/sclk/mosi in the clk domain, shifts a preloaded
// word out on miso and returns each completed received word as a one-cycle strobe.
module rp_spi_slave #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs,
    input  logic          sclk,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_wen,
    output logic          tx_ready,
    output logic          tx_underrun,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          busy
);

    localparam int CW = $clog2(DW);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state_q;
    logic          csMeta_q, csSync_q, csDly_q;
    logic          sclkMeta_q, sclkSync_q, sclkDly_q;
    logic          mosiMeta_q, mosiSync_q;
    logic [DW-1:0] txBuf_q;
    logic          txReady_q;
    logic          underrun_q;
    logic [DW-1:0] txs_q;
    logic [DW-1:0] rxs_q;
    logic [DW-1:0] rxData_q;
    logic          rxValid_q;
    logic [CW-1:0] bitCnt_q;
    logic          reload_q;

    logic          csFall, sclkRise, sclkFall;
    logic          doLoad_d;
    logic [DW-1:0] loadVal_d;
    logic [DW-1:0] rxsNext_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csMeta_q   <= 1'b1;
            csSync_q   <= 1'b1;
            csDly_q    <= 1'b1;
            sclkMeta_q <= 1'b0;
            sclkSync_q <= 1'b0;
            sclkDly_q  <= 1'b0;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
        end else begin
            csMeta_q   <= cs;
            csSync_q   <= csMeta_q;
            csDly_q    <= csSync_q;
            sclkMeta_q <= sclk;
            sclkSync_q <= sclkMeta_q;
            sclkDly_q  <= sclkSync_q;
            mosiMeta_q <= mosi;
            mosiSync_q <= mosiMeta_q;
        end
    end

    assign csFall   = csDly_q & ~csSync_q;
    assign sclkRise = sclkSync_q & ~sclkDly_q;
    assign sclkFall = ~sclkSync_q & sclkDly_q;

    // A load fires on entry to SHIFT and on the sclk fall after a word completes;
    // an empty buffer loads zeros.
    always_comb begin
        doLoad_d  = ((state_q == IDLE) && csFall) ||
                    ((state_q == SHIFT) && !csSync_q && sclkFall && reload_q);
        loadVal_d = txReady_q ? '0 : txBuf_q;
        rxsNext_d = {rxs_q[DW-2:0], mosiSync_q};
    end

    // The load sees the buffer state from before any same-cycle write, so a write
    // coinciding with an underrun is kept for the following slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txBuf_q    <= '0;
            txReady_q  <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= doLoad_d & txReady_q;
            if (doLoad_d && !txReady_q) begin
                txReady_q <= 1'b1;
            end else if (tx_wen && txReady_q) begin
                txBuf_q   <= tx_data;
                txReady_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            txs_q     <= '0;
            rxs_q     <= '0;
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            bitCnt_q  <= '0;
            reload_q  <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (csFall) begin
                        state_q  <= SHIFT;
                        txs_q    <= loadVal_d;
                        bitCnt_q <= '0;
                        reload_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Deselect beats a coincident sclk rise; partial words vanish.
                    if (csSync_q) begin
                        state_q  <= IDLE;
                        bitCnt_q <= '0;
                        rxs_q    <= '0;
                        reload_q <= 1'b0;
                    end else if (sclkRise) begin
                        rxs_q <= rxsNext_d;
                        if (bitCnt_q == CW'(DW - 1)) begin
                            rxData_q  <= rxsNext_d;
                            rxValid_q <= 1'b1;
                            bitCnt_q  <= '0;
                            reload_q  <= 1'b1;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end else if (sclkFall) begin
                        if (reload_q) begin
                            txs_q    <= loadVal_d;
                            reload_q <= 1'b0;
                        end else begin
                            txs_q <= {txs_q[DW-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso        = ~csSync_q & txs_q[DW-1];
    assign miso_oe     = ~csSync_q;
    assign tx_ready    = txReady_q;
    assign tx_underrun = underrun_q;
    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_rp_spi_slave.sv
// Directed and randomized frames against rp_spi_slave; a slot-based reference model
// predicts the words seen on miso, the received words and the underrun count.
`timescale 1ns/1ps
module tb_rp_spi_slave;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cs = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, miso_oe;
    logic [15:0] tx_data = '0;
    logic        tx_wen = 1'b0;
    logic        tx_ready, tx_underrun;
    logic [15:0] rx_data;
    logic        rx_valid, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: the holding buffer as a queue of at most one word.
    logic [15:0] txQ[$];
    logic [15:0] expRx[$];
    logic [15:0] rxGot[$];
    int          expUr = 0;
    int          urCnt = 0;
    logic [15:0] lastRx = '0;
    logic [15:0] mosiArr[4];
    logic [15:0] misoGot[4];
    logic [15:0] expSlot[4];

    rp_spi_slave #(.DW(16)) dut (
        .clk(clk), .rstn(rstn), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_wen(tx_wen),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Collects strobes away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) rxGot.push_back(rx_data);
        if (tx_underrun) urCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clkWait(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] modelLoad();
        if (txQ.size() != 0) return txQ.pop_front();
        expUr++;
        return 16'h0000;
    endfunction

    function automatic void modelWrite(input logic [15:0] w);
        if (txQ.size() == 0) txQ.push_back(w);
    endfunction

    task automatic applyStimulus(input logic [15:0] w);
        tx_data = w;
        tx_wen  = 1'b1;
        @(negedge clk);
        tx_wen  = 1'b0;
        modelWrite(w);
    endtask

    // Master side of a frame: nBits sclk periods at clk/8, optional write at bit wrBit.
    task automatic runFrame(input int nBits, input int wrBit, input logic [15:0] wrWord,
                            input bit keepCs);
        cs = 1'b0;
        expSlot[0] = modelLoad();
        clkWait(4);
        for (int b = 0; b < nBits; b++) begin
            int w = b / 16;
            int i = 15 - (b % 16);
            mosi = mosiArr[w][i];
            if (b == wrBit) begin
                applyStimulus(wrWord);
                clkWait(3);
            end else begin
                clkWait(4);
            end
            misoGot[w][i] = miso;
            sclk = 1'b1;
            clkWait(4);
            sclk = 1'b0;
            if ((b % 16) == 15) begin
                expSlot[w + 1] = modelLoad();
                expRx.push_back(mosiArr[w]);
            end
        end
        clkWait(4);
        if (!keepCs) begin
            cs = 1'b1;
            clkWait(6);
        end
    endtask

    task automatic checkOutput(input string tag, input int nWords);
        for (int w = 0; w < nWords; w++)
            check($sformatf("%s_miso%0d", tag, w), {16'h0, misoGot[w]}, {16'h0, expSlot[w]});
        check($sformatf("%s_rxcnt", tag), rxGot.size(), expRx.size());
        for (int k = 0; k < expRx.size() && k < rxGot.size(); k++)
            check($sformatf("%s_rx%0d", tag, k), {16'h0, rxGot[k]}, {16'h0, expRx[k]});
        if (expRx.size() != 0) lastRx = expRx[expRx.size() - 1];
        check($sformatf("%s_rxdata", tag), {16'h0, rx_data}, {16'h0, lastRx});
        check($sformatf("%s_underruns", tag), urCnt, expUr);
        check($sformatf("%s_txready", tag), {31'h0, tx_ready}, {31'h0, (txQ.size() == 0)});
        check($sformatf("%s_busy", tag), {31'h0, busy}, 32'h0);
        rxGot.delete();
        expRx.delete();
    endtask

    initial begin
        int urBefore;

        // Reset then idle.
        clkWait(3);
        rstn = 1'b1;
        clkWait(2);
        check("rst_txready", {31'h0, tx_ready}, 32'h1);
        check("rst_misooe", {31'h0, miso_oe}, 32'h0);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_rxdata", {16'h0, rx_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        clkWait(100);
        check("idle_rxvalid", rxGot.size(), 0);
        check("idle_underrun", urCnt, 0);

        // Single frame with tx_ready timing around the cs-fall load.
        applyStimulus(16'hA5C3);
        check("single_txready_full", {31'h0, tx_ready}, 32'h0);
        mosiArr[0] = 16'h1234;
        cs = 1'b0;
        clkWait(2);
        check("single_txready_preload", {31'h0, tx_ready}, 32'h0);
        clkWait(1);
        check("single_txready_post", {31'h0, tx_ready}, 32'h1);
        check("single_misooe", {31'h0, miso_oe}, 32'h1);
        check("single_busy", {31'h0, busy}, 32'h1);
        cs = 1'b1;
        clkWait(6);
        txQ.delete();
        expUr = urCnt;
        applyStimulus(16'hA5C3);
        runFrame(16, -1, 16'h0, 1'b0);
        check("single_miso_const", {16'h0, misoGot[0]}, 32'hA5C3);
        checkOutput("single", 1);

        // Back-to-back words with a write during word 1.
        applyStimulus(16'h0001);
        mosiArr[0] = 16'hBEEF;
        mosiArr[1] = 16'hCAFE;
        runFrame(32, 3, 16'h0002, 1'b0);
        check("b2b_w0_const", {16'h0, misoGot[0]}, 32'h0001);
        check("b2b_w1_const", {16'h0, misoGot[1]}, 32'h0002);
        checkOutput("b2b", 2);

        // Underrun at the cs fall.
        mosiArr[0] = 16'h5A3C;
        urBefore = urCnt;
        cs = 1'b0;
        clkWait(6);
        check("ur_at_csfall", urCnt - urBefore, 1);
        cs = 1'b1;
        clkWait(6);
        expUr = urCnt;
        runFrame(16, -1, 16'h0, 1'b0);
        check("ur_miso_zero", {16'h0, misoGot[0]}, 32'h0);
        checkOutput("underrun", 1);

        // Aborted frame after 7 sclk, then a full frame.
        applyStimulus(16'h3C3C);
        mosiArr[0] = 16'hFFFF;
        runFrame(7, -1, 16'h0, 1'b0);
        checkOutput("abort", 0);
        applyStimulus(16'h9876);
        mosiArr[0] = 16'h4321;
        runFrame(16, -1, 16'h0, 1'b0);
        checkOutput("after_abort", 1);

        // Reset mid-frame with the buffer full.
        applyStimulus(16'h1111);
        mosiArr[0] = 16'h7777;
        runFrame(9, 2, 16'h2222, 1'b1);
        check("mid_txready_full", {31'h0, tx_ready}, 32'h0);
        rstn = 1'b0;
        #2;
        check("mid_txready", {31'h0, tx_ready}, 32'h1);
        check("mid_miso", {31'h0, miso}, 32'h0);
        check("mid_misooe", {31'h0, miso_oe}, 32'h0);
        check("mid_busy", {31'h0, busy}, 32'h0);
        check("mid_rxdata", {16'h0, rx_data}, 32'h0);
        txQ.delete();
        expRx.delete();
        lastRx = '0;
        cs = 1'b1;
        clkWait(3);
        rstn = 1'b1;
        clkWait(3);
        rxGot.delete();
        expUr = urCnt;
        applyStimulus(16'h6B6B);
        mosiArr[0] = 16'hD00D;
        runFrame(16, -1, 16'h0, 1'b0);
        checkOutput("fresh", 1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            int nWords = $urandom_range(1, 3);
            int wrBit  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nWords * 16 - 2) : -1;
            for (int w = 0; w < 4; w++) mosiArr[w] = 16'($urandom);
            if ($urandom_range(0, 3) != 0) applyStimulus(16'($urandom));
            if ($urandom_range(0, 3) == 0) applyStimulus(16'($urandom));
            runFrame(nWords * 16, wrBit, 16'($urandom), 1'b0);
            checkOutput($sformatf("rand%0d", f), nWords);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/rp_spi_slave.md
# rp_spi_slave

SPI mode-0 responder (target) for the Red Pitaya fabric, the counterpart to the sys-bus-driven SPI initiator. It oversamples the external `cs`/`sclk`/`mosi` lines in the `clk` domain, shifts out a preloaded transmit word on `miso`, and delivers each completed received word to the parallel side as a one-cycle strobe. Benches use it as a loopback partner for the initiator. Boards use it to expose fabric registers to an external SPI master.

## Interface
Parameters:
- `DW`, 16, word length in bits; MSB first; legal 4..32.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, CPOL=0, asynchronous to `clk`.
- `mosi`  in  1  SPI data in, asynchronous to `clk`.
- `miso`  out  1  SPI data out; 0 when not selected.
- `miso_oe`  out  1  output enable for the `miso` pad; 1 while selected.
- `tx_data`  in  DW  word to transmit next.
- `tx_wen`  in  1  write strobe for `tx_data`; accepted only when `tx_ready`=1.
- `tx_ready`  out  1  transmit holding buffer empty.
- `tx_underrun`  out  1  one-cycle pulse: a word slot started with the buffer empty; zeros are sent.
- `rx_data`  out  DW  last completed received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  1 while in SHIFT.

## Operation
- Synchronizer: 2-FF chains on `cs`, `sclk`, `mosi`. Reset values are `cs`=1, `sclk`=0, `mosi`=0. One further register on synchronized `sclk` gives rise and fall detects.
- Transmit path: one-word holding buffer plus a shift register `txs`.
  - `tx_wen` with `tx_ready`=1 stores the word and clears `tx_ready`.
  - `tx_wen` with `tx_ready`=0 is ignored; the buffer is unchanged.
- "Load" means:
  - Buffer full: `txs`←buffer, and `tx_ready`←1 on the next cycle.
  - Buffer empty: `txs`←0 and `tx_underrun` pulses.
- Load and `tx_wen` in the same cycle: the load uses the prior buffer state, and the written word is stored for the next slot.
- FSM states: IDLE, SHIFT.
  - IDLE→SHIFT on a synchronized `cs` falling edge. Load happens, and `bitcnt`←0.
  - SHIFT, sclk rise: `rxs`←{`rxs`[DW-2:0], `mosi_s`} and `bitcnt`++.
    - When `bitcnt` was DW-1: `rx_data`←new `rxs` value, `rx_valid` pulses, `bitcnt`←0, and the reload flag is set.
  - SHIFT, sclk fall: if the reload flag is set, load and clear the flag; otherwise `txs`←`txs`<<1.
  - SHIFT→IDLE on synchronized `cs`=1. A partial `rxs` is discarded with no `rx_valid`. The partially sent word is lost and not returned to the buffer. The holding buffer is untouched.
- `miso` = `txs`[DW-1] while synchronized `cs`=0, else 0. `miso_oe` = ~synchronized `cs`.
- Continuous frames: with `cs` held low, words are back-to-back with no gap bit.
- An sclk rise and `cs` deassert in the same cycle: the `cs` deassert wins and the sample is dropped.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `tx_underrun`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, FSM=IDLE, all shift registers and counters 0.
- Async reset mid-frame returns everything to reset values immediately. The holding buffer is emptied.
- Pin-to-detect latency: 2 `clk` edges.
  - `rx_valid` is high after the 3rd `clk` edge following the final sclk rise at the pin.
  - `miso` updates after the 3rd `clk` edge following an sclk fall or `cs` fall at the pin.
- Required master timing:
  - `sclk` high and low phases ≥4 `clk` periods each, so sclk ≤ clk/8.
  - `cs` fall to first sclk rise ≥4 `clk` periods.
  - Last sclk fall to `cs` rise ≥4 `clk` periods.
- `tx_ready` reasserts 1 cycle after the load that consumed the buffer.
- Next-word `tx_data` must be written before the falling sclk edge that follows bit DW-1; otherwise an underrun occurs.

## Test plan
- Reset then idle: after `rstn` rises, `tx_ready`=1, `miso_oe`=0, `rx_valid` never pulses over 100 cycles.
- Single frame, DW=16:
  - Stimulus: write `tx_data`=0xA5C3; master sends `mosi`=0x1234 at sclk=clk/8.
  - Response: master samples 0xA5C3 on `miso`; one `rx_valid` pulse with `rx_data`=0x1234; `tx_ready` returns to 1 one cycle after the `cs` fall load.
- Back-to-back:
  - Stimulus: preload 0x0001; write 0x0002 during word 1; hold `cs` low for 32 sclk.
  - Response: `miso` stream 0x0001,0x0002; two `rx_valid` pulses with the 0xBEEF,0xCAFE sent by the master.
- Underrun: no write before frame; master sends 16 clocks. Response: `tx_underrun` pulses once at the `cs` fall; `miso` is all zeros; `rx_data` is still correct.
- Aborted frame: `cs` rises after 7 sclk. Response: no `rx_valid`; `rx_data` keeps its previous value; the next full frame receives correctly from bit 0.
- Reset mid-frame: `rstn` low after 9 sclk with the buffer full. Response: all outputs reach reset values; `tx_ready`=1; a subsequent frame behaves as a fresh one.
